// File: rtl/lv1_bus_port_arbiter.sv
// Round-robin arbiter that funnels a core's lv1 request channels onto the single
// lv1-lv2 bus request, with one-hot channel grants and a sticky grant-hold watchdog.
module lv1_bus_port_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int CH_WID   = 1,
  parameter int MAX_HOLD = 64,
  parameter int HOLD_WID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_gnt,
  output logic              bus_lv1_lv2_req_proc,
  input  logic              bus_lv1_lv2_gnt_proc,
  output logic [CH_WID-1:0] owner,
  output logic              busy,
  output logic              hold_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

  state_t              state_reg;
  logic [CH_WID-1:0]   rr_ptr_reg;
  logic [HOLD_WID-1:0] hold_cnt_reg;

  logic [CH_WID-1:0]   owner_inc;
  logic [CH_WID-1:0]   arb_ptr;
  logic [CH_WID-1:0]   cand_idx [NUM_CH];
  logic [NUM_CH-1:0]   cand_hit;
  logic [NUM_CH-1:0]   owner_hot;
  logic [CH_WID-1:0]   pick_idx;
  logic [HOLD_WID-1:0] hold_inc;
  logic                any_req;
  logic                owner_req;
  logic                owner_done;

  assign owner_inc  = (owner == CH_WID'(NUM_CH - 1)) ? '0 : owner + CH_WID'(1);
  // In RELEASE the pointer update and the next pick happen in the same cycle.
  assign arb_ptr    = (state_reg == RELEASE) ? owner_inc : rr_ptr_reg;
  assign any_req    = |ch_req;
  assign owner_req  = ch_req[owner];
  assign owner_done = ch_done[owner];
  assign hold_inc   = (&hold_cnt_reg) ? hold_cnt_reg : hold_cnt_reg + HOLD_WID'(1);

  // Candidate gi is the channel gi places after the pointer, wrapping modulo NUM_CH.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
    logic [CH_WID:0] sum;
    assign sum          = {1'b0, arb_ptr} + (CH_WID+1)'(gi);
    assign cand_idx[gi] = (sum >= (CH_WID+1)'(NUM_CH)) ? CH_WID'(sum - (CH_WID+1)'(NUM_CH))
                                                       : sum[CH_WID-1:0];
    assign cand_hit[gi]  = ch_req[cand_idx[gi]];
    assign owner_hot[gi] = (owner == CH_WID'(gi));
  end

  always_comb begin
    pick_idx = cand_idx[0];
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cand_hit[i]) pick_idx = cand_idx[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg            <= IDLE;
      rr_ptr_reg           <= '0;
      hold_cnt_reg         <= '0;
      ch_gnt               <= '0;
      bus_lv1_lv2_req_proc <= 1'b0;
      owner                <= '0;
      busy                 <= 1'b0;
      hold_timeout         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner                <= pick_idx;
            bus_lv1_lv2_req_proc <= 1'b1;
            busy                 <= 1'b1;
            state_reg            <= REQ;
          end
        end
        REQ: begin
          if (!owner_req) begin
            bus_lv1_lv2_req_proc <= 1'b0;
            state_reg            <= RELEASE;
          end else if (bus_lv1_lv2_gnt_proc) begin
            ch_gnt    <= owner_hot;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt_reg <= hold_inc;
          if (hold_inc >= HOLD_WID'(MAX_HOLD)) hold_timeout <= 1'b1;
          // Done, withdrawal and revocation all collapse into a single release.
          if (owner_done || !owner_req || !bus_lv1_lv2_gnt_proc) begin
            ch_gnt               <= '0;
            bus_lv1_lv2_req_proc <= 1'b0;
            state_reg            <= RELEASE;
          end
        end
        RELEASE: begin
          rr_ptr_reg   <= owner_inc;
          hold_cnt_reg <= '0;
          if (any_req) begin
            owner                <= pick_idx;
            bus_lv1_lv2_req_proc <= 1'b1;
            state_reg            <= REQ;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lv1_bus_port_arbiter.sv
// Scoreboarded random/directed bench for lv1_bus_port_arbiter (4 channels, MAX_HOLD = 4).
module tb_lv1_bus_port_arbiter;
  localparam int NCH  = 4;
  localparam int CW   = 2;
  localparam int MAXH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_req, ch_done, ch_gnt;
  logic           req_proc, gnt_proc;
  logic [CW-1:0]  owner;
  logic           busy, hold_timeout;

  int checks = 0;
  int passes = 0;
  int exp_q[$];
  int model_ptr = 0;
  bit to_exp = 1'b0;
  int hold_tgt[NCH];
  logic [NCH-1:0] prev_gnt = '0;

  always #5 clk = ~clk;

  lv1_bus_port_arbiter #(.NUM_CH(NCH), .CH_WID(CW), .MAX_HOLD(MAXH), .HOLD_WID(8)) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .ch_req               (ch_req),
    .ch_done              (ch_done),
    .ch_gnt               (ch_gnt),
    .bus_lv1_lv2_req_proc (req_proc),
    .bus_lv1_lv2_gnt_proc (gnt_proc),
    .owner                (owner),
    .busy                 (busy),
    .hold_timeout         (hold_timeout)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Monitor: every new grant pops the scoreboard; invariants checked each cycle.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_gnt = '0;
    end else begin
      check("onehot", int'($countones(ch_gnt) <= 1), 1);
      if (ch_gnt != '0) check("gnt_needs_bus", int'(gnt_proc), 1);
      if (ch_gnt != '0 && prev_gnt == '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", int'(ch_gnt), 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("grant_vec", int'(ch_gnt), 1 << e);
          check("grant_owner", int'(owner), e);
        end
      end
      prev_gnt = ch_gnt;
    end
  end

  // Bus and channel agents until everything is served and the arbiter is idle.
  task automatic run_agents(input int exp_rel);
    int held[NCH];
    int rel = 0;
    int bw;
    bit done_ok = 1'b0;
    bw = $urandom_range(0, 3);
    for (int c = 0; c < NCH; c++) held[c] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (busy && !req_proc) rel++;
      if (req_proc) begin
        if (bw == 0) gnt_proc = 1'b1;
        else bw--;
      end else begin
        gnt_proc = 1'b0;
        bw = $urandom_range(0, 3);
      end
      ch_done = '0;
      for (int c = 0; c < NCH; c++) begin
        if (ch_gnt[c]) begin
          held[c]++;
          if (held[c] >= MAXH + 2) to_exp = 1'b1;
          if (held[c] <= MAXH || held[c] >= MAXH + 2)
            check("hold_timeout", int'(hold_timeout), int'(to_exp));
          if (held[c] == hold_tgt[c]) begin
            ch_done[c] = 1'b1;
            ch_req[c]  = 1'b0;
          end
        end
      end
      if (ch_req == '0 && ch_done == '0 && !busy) begin
        done_ok = 1'b1;
        break;
      end
    end
    check("round_finished", int'(done_ok), 1);
    check("release_cycles", rel, exp_rel);
    check("timeout_sticky", int'(hold_timeout), int'(to_exp));
  endtask

  // Held requests are served in circular order starting at the round-robin pointer.
  task automatic round(input logic [NCH-1:0] mask);
    int last = 0;
    for (int i = 0; i < NCH; i++) begin
      int c = (model_ptr + i) % NCH;
      if (mask[c]) begin
        exp_q.push_back(c);
        last = c;
      end
    end
    model_ptr = (last + 1) % NCH;
    for (int c = 0; c < NCH; c++) hold_tgt[c] = $urandom_range(1, 3);
    @(negedge clk);
    ch_req = mask;
    run_agents($countones(mask));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ch_req = '0; ch_done = '0; gnt_proc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    to_exp = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ch_req = '0; ch_done = '0; gnt_proc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", int'(ch_gnt), 0);
    check("rst_req_proc", int'(req_proc), 0);
    check("rst_owner", int'(owner), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(hold_timeout), 0);
    rst = 1'b0;

    // Single IL transaction with exact cycle timing.
    exp_q.push_back(0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      check("t1_req_proc", int'(req_proc), int'(cyc >= 1 && cyc <= 6));
      check("t1_gnt", int'(ch_gnt), (cyc >= 4 && cyc <= 6) ? 1 : 0);
      check("t1_busy", int'(busy), int'(cyc >= 1 && cyc <= 7));
      ch_req   = (cyc <= 6) ? 4'b0001 : 4'b0000;
      gnt_proc = (cyc >= 3 && cyc <= 6);
      ch_done  = (cyc == 6) ? 4'b0001 : 4'b0000;
    end
    model_ptr = 1;
    round(4'b0011);

    // IL and DL contending from pointer 0, twice.
    do_reset();
    round(4'b0011);
    round(4'b0011);

    repeat (20) round(4'($urandom_range(1, 15)));

    // Withdrawal of DL before any bus grant.
    @(negedge clk);
    ch_req = 4'b0010; gnt_proc = 1'b0;
    @(negedge clk);
    check("wd_req", int'(req_proc), 1);
    check("wd_busy", int'(busy), 1);
    ch_req = '0;
    @(negedge clk);
    check("wd_release", int'(req_proc), 0);
    check("wd_rel_busy", int'(busy), 1);
    check("wd_gnt", int'(ch_gnt), 0);
    @(negedge clk);
    check("wd_idle", int'(busy), 0);
    model_ptr = 2;

    // Revocation in grant cycle 3, then re-request of the same channel.
    exp_q.push_back(0);
    exp_q.push_back(0);
    model_ptr = 1;
    @(negedge clk);
    ch_req = 4'b0001;
    @(negedge clk);
    gnt_proc = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      @(negedge clk);
      check("rv_gnt", int'(ch_gnt), 1);
      if (g == 3) gnt_proc = 1'b0;
    end
    @(negedge clk);
    check("rv_gnt_off", int'(ch_gnt), 0);
    check("rv_release", int'(req_proc), 0);
    check("rv_busy", int'(busy), 1);
    @(negedge clk);
    check("rv_rereq", int'(req_proc), 1);
    check("rv_owner", int'(owner), 0);
    hold_tgt[0] = 2;
    run_agents(1);

    // Grant held 10 cycles trips the sticky hold watchdog.
    exp_q.push_back(2);
    model_ptr = 3;
    hold_tgt[2] = 10;
    @(negedge clk);
    ch_req = 4'b0100;
    run_agents(1);
    check("to_set", int'(hold_timeout), 1);

    // Asynchronous reset in the middle of a grant.
    exp_q.push_back(3);
    @(negedge clk);
    ch_req = 4'b1000;
    for (int i = 0; i < 20 && ch_gnt == '0; i++) begin
      @(negedge clk);
      gnt_proc = req_proc;
    end
    check("mg_reached", int'(ch_gnt != '0), 1);
    #2 rst = 1'b1;
    #1;
    check("mg_gnt", int'(ch_gnt), 0);
    check("mg_req_proc", int'(req_proc), 0);
    check("mg_owner", int'(owner), 0);
    check("mg_busy", int'(busy), 0);
    check("mg_timeout", int'(hold_timeout), 0);
    ch_req = '0; ch_done = '0; gnt_proc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    to_exp = 1'b0;

    // All four channels contending: rotation 0,1,2,3 and wrap back to 0.
    round(4'b1111);
    round(4'b1111);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
